// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared widths, length-field size and loader state enum (PROG_LOADER_CHECKSUM_EN adds S_SUM/S_ERR)
package prog_loader_pkg;

    localparam int DEFAULT_INST_WIDTH     = 32;
    localparam int DEFAULT_INST_MEM_WIDTH = 8;
    localparam int LEN_BYTES              = 4;
    localparam int LEN_WIDTH              = LEN_BYTES * 8;

    typedef enum logic [2:0] {
        S_PRE,
        S_LEN,
        S_WORD,
        S_FIN,
        S_DONE
`ifdef PROG_LOADER_CHECKSUM_EN
        ,
        S_SUM,
        S_ERR
`endif
    } state_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// rtl/prog_loader_word_assembler.sv - big-endian byte shifter; word_ready flags the byte that completes a word
module word_assembler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic [WIDTH-1:0] word,
    output logic             word_ready
);

    localparam int NB = WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0] cnt;

    assign word_ready = byte_valid && (cnt == CW'(NB - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word <= '0;
            cnt  <= '0;
        end else if (byte_valid) begin
            word <= {word[WIDTH-9:0], byte_data};
            cnt  <= word_ready ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART program loader into instruction memory; PROG_LOADER_CHECKSUM_EN enables the XOR trailer check
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INST_WIDTH     = DEFAULT_INST_WIDTH,
    parameter int INST_MEM_WIDTH = DEFAULT_INST_MEM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [INST_WIDTH-1:0] inst_in,
    output logic                  we,
    output logic                  stall,
    output logic                  reset_pc,
    output logic                  done,
    output logic                  err
);

    state_t                  state, state_nx;
    logic [LEN_WIDTH-1:0]    len_word;
    logic [LEN_WIDTH-1:0]    len_next;
    logic                    len_ready;
    logic [INST_WIDTH-1:0]   inst_word;
    logic                    inst_ready;
    logic [31:0]             word_cnt;
    logic                    we_q;
    logic                    in_range;
    logic                    final_word;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t AFTER_WORDS = S_SUM;
    logic [7:0] csum;
`else
    localparam state_t AFTER_WORDS = S_FIN;
    logic word_done_q;
`endif

    word_assembler #(.WIDTH(LEN_WIDTH)) u_len (
        .clk        (clk),
        .rstn       (rstn),
        .byte_data  (rx_data),
        .byte_valid (rx_valid && state == S_LEN),
        .word       (len_word),
        .word_ready (len_ready)
    );

    word_assembler #(.WIDTH(INST_WIDTH)) u_inst (
        .clk        (clk),
        .rstn       (rstn),
        .byte_data  (rx_data),
        .byte_valid (rx_valid && state == S_WORD),
        .word       (inst_word),
        .word_ready (inst_ready)
    );

    // N must be known on the 4th length byte itself, before the shifter has absorbed it
    assign len_next   = {len_word[LEN_WIDTH-9:0], rx_data};
    assign in_range   = ({1'b0, word_cnt} < (33'd1 << INST_MEM_WIDTH));
    assign final_word = (word_cnt + 32'd1) == len_word;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_PRE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_PRE:  state_nx = S_LEN;
            S_LEN:  if (len_ready) state_nx = (len_next != '0) ? S_WORD : AFTER_WORDS;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_WORD: if (inst_ready && final_word) state_nx = S_SUM;
            S_SUM:  if (rx_valid) state_nx = (rx_data == csum) ? S_FIN : S_ERR;
`else
            // leave only after the last we cycle so reset_pc never overlaps a write
            S_WORD: if (word_done_q && word_cnt == len_word) state_nx = S_FIN;
`endif
            S_FIN:  state_nx = S_DONE;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_cnt <= '0;
            we_q     <= 1'b0;
        end else begin
            we_q <= (state == S_WORD) && inst_ready && in_range;
            if (state == S_WORD && inst_ready) word_cnt <= word_cnt + 32'd1;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            csum <= '0;
        else if (rx_valid && (state == S_LEN || state == S_WORD))
            csum <= csum ^ rx_data;
    end
    assign err = (state == S_ERR);
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) word_done_q <= 1'b0;
        else       word_done_q <= (state == S_WORD) && inst_ready;
    end
    assign err = 1'b0;
`endif

    assign we       = we_q;
    assign inst_in  = inst_word;
    assign stall    = !((state == S_DONE) || we_q);
    assign reset_pc = rstn && (state == S_PRE || state == S_FIN);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized scoreboard bench for prog_loader (honours PROG_LOADER_CHECKSUM_EN)
module tb_prog_loader;

    localparam int IW    = 32;
    localparam int MW    = 2;
    localparam int DEPTH = 1 << MW;

    typedef struct {
        int          idx;
        logic [IW-1:0] word;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [IW-1:0] inst_in;
    logic          we, stall, reset_pc, done, err;

    int            compared = 0;
    int            mismatched = 0;
    exp_t          expq[$];
    logic [IW-1:0] wq[$];
    int            pc_model = 0;
    int            rpc_cnt = 0;

    always #5 clk = ~clk;

    prog_loader #(.INST_WIDTH(IW), .INST_MEM_WIDTH(MW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .inst_in  (inst_in),
        .we       (we),
        .stall    (stall),
        .reset_pc (reset_pc),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: core-side pc model plus scoreboard of memory writes
    always @(negedge clk) begin
        check("stall_rule", stall, !(we || done));
        if (we) begin
            if (expq.size() == 0) begin
                check("unexpected_we", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("we_word", inst_in, e.word);
                check("we_pc", pc_model, e.idx);
            end
            pc_model++;
        end
        if (reset_pc) begin
            pc_model = 0;
            rpc_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_mode, inout logic [7:0] sum);
        rx_data  = b;
        rx_valid = 1'b1;
        sum      = sum ^ b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        if (gap_mode != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_we", we, 0);
        check("rst_reset_pc", reset_pc, 0);
        check("rst_stall", stall, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_inst_in", inst_in, 0);
        repeat (2) @(posedge clk);
        #1;
        rpc_cnt = 0;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_len(input int n, input int gap_mode, inout logic [7:0] sum);
        logic [31:0] nv;
        nv = n;
        for (int i = 3; i >= 0; i--) send_byte(nv[8*i +: 8], gap_mode, sum);
    endtask

    task automatic send_word(input int k, input int gap_mode, inout logic [7:0] sum);
        logic [IW-1:0] w;
        exp_t e;
        w = wq[k];
        if (k < DEPTH) begin
            e.idx = k;
            e.word = w;
            expq.push_back(e);
        end
        for (int b = IW / 8 - 1; b >= 0; b--) send_byte(w[8*b +: 8], gap_mode, sum);
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(done || err) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("end_timeout", (t < 200), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // drives a complete stream from wq and checks the terminal state
    task automatic run_stream(input int gap_mode, input bit bad_sum);
        logic [7:0] sum;
        sum = 8'h00;
        send_len(wq.size(), gap_mode, sum);
        for (int k = 0; k < wq.size(); k++) send_word(k, gap_mode, sum);
`ifdef PROG_LOADER_CHECKSUM_EN
        begin
            logic [7:0] tr;
            tr = bad_sum ? (sum ^ 8'h03) : sum;
            send_byte(tr, 0, sum);
        end
`endif
        wait_end();
        check("we_count", expq.size(), 0);
        expq.delete();
        if (bad_sum) begin
            check("bad_err", err, 1);
            check("bad_done", done, 0);
            check("bad_stall", stall, 1);
            check("bad_reset_pc_pulses", rpc_cnt, 1);
        end else begin
            check("done", done, 1);
            check("err", err, 0);
            check("reset_pc_pulses", rpc_cnt, 2);
            for (int i = 0; i < 5; i++) begin
                logic [7:0] junk;
                junk = sum;
                send_byte(8'($urandom), 0, junk);
            end
            check("done_sticky", done, 1);
            check("reset_pc_after_done", rpc_cnt, 2);
        end
    endtask

    initial begin
        #2;
        do_reset();

        wq = {32'h11223344, 32'hAABBCCDD};
        run_stream(1, 1'b0);

        do_reset();
        wq.delete();
        run_stream(0, 1'b0);

        do_reset();
        wq = {32'h01020304};
        run_stream(0, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
        do_reset();
        run_stream(0, 1'b1);
`endif

        do_reset();
        wq.delete();
        for (int i = 0; i < 6; i++) wq.push_back($urandom);
        run_stream(0, 1'b0);

        // reset part-way through the second word, then a fresh stream
        do_reset();
        wq = {32'hDEADBEEF, 32'h0BADF00D, 32'h12345678};
        begin
            logic [7:0] s;
            s = 8'h00;
            send_len(3, 0, s);
            send_word(0, 0, s);
            send_byte(8'h0B, 0, s);
            send_byte(8'hAD, 0, s);
        end
        do_reset();
        check("midreset_pending", expq.size(), 0);
        expq.delete();
        wq = {32'hCAFEBABE, 32'h55AA55AA, 32'h0F0F0F0F};
        run_stream(0, 1'b0);

        for (int it = 0; it < 8; it++) begin
            do_reset();
            wq.delete();
            for (int i = 0, n = $urandom_range(0, 7); i < n; i++) wq.push_back($urandom);
            run_stream($urandom_range(0, 1), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rstn  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: rx_data  input  8  received byte from the UART receiver.
REQ-004 SHALL: rx_valid  input  1  one-cycle pulse qualifying rx_data.
REQ-005 SHALL: inst_in  output  INST_WIDTH  assembled instruction word for the instruction memory write port.
REQ-006 SHALL: we  output  1  one-cycle write strobe; memory writes inst_in at its current pc.
REQ-007 SHALL: stall  output  1  holds core pc and fetch while high.
REQ-008 SHALL: reset_pc  output  1  one-cycle pulse that zeroes core pc.
REQ-009 SHALL: done  output  1  level; program loaded and core released.
REQ-010 SHALL: err  output  1  level; checksum failure, sticky until reset.

Function
REQ-011 SHALL: stream format is a 4-byte big-endian word count N, then N words of INST_WIDTH/8 bytes each, big-endian.
REQ-012 SHALL: FSM states are S_PRE, S_LEN, S_WORD, S_SUM, S_FIN, S_DONE, S_ERR.
REQ-013 SHALL: S_PRE lasts exactly one cycle with reset_pc=1, then goes to S_LEN.
REQ-014 SHALL: S_LEN shifts in 4 bytes; after the 4th byte the FSM goes to S_WORD if N!=0, else to S_SUM (macro on) or S_FIN (macro off).
REQ-015 SHALL: S_WORD shifts bytes into the word register; on the last byte of a word, inst_in holds the full word and we=1 and stall=0 for exactly the next cycle, then stall returns to 1.
REQ-016 SHALL: words with index >= 2**INST_MEM_WIDTH are consumed without we and with stall held high, so pc never wraps.
REQ-017 SHALL: after word N-1 is written, the FSM goes to S_SUM (macro on) or S_FIN (macro off).
REQ-018 SHALL: S_FIN lasts one cycle with reset_pc=1 and stall=1, then goes to S_DONE.
REQ-019 SHALL: S_DONE drives done=1 and stall=0, ignores all further rx_valid, and is left only by reset.
REQ-020 SHALL: stall=1 in every state except S_DONE and the we cycle.
REQ-021 SHALL: rx_valid during the we cycle is accepted as the first byte of the next item, with no byte loss.
REQ-022 SHALL: the byte counter wraps to 0 after each completed word, and the 32-bit word counter compares against N with no truncation.

Reset
REQ-023 SHALL: rstn low forces S_PRE, with we=0, reset_pc=0, stall=1, done=0, err=0, inst_in=0, and all counters and shift registers cleared.
REQ-024 SHALL: reset asserted mid-load abandons the partial word and restarts the protocol from S_PRE; words already written remain in memory.

Configuration
REQ-025 SHALL: with PROG_LOADER_CHECKSUM_EN defined, one trailer byte follows the last word; it is compared in S_SUM with the XOR of all preceding length and word bytes; a match goes to S_FIN, a mismatch goes to S_ERR (err=1, stall=1, done=0, no reset_pc).
REQ-026 SHALL: without PROG_LOADER_CHECKSUM_EN, S_SUM and S_ERR are absent, no trailer byte is expected, and err is tied to 0.

Structure
REQ-027 SHALL: INST_WIDTH and INST_MEM_WIDTH come from the shared common header; the loader state enum and the length-field byte count live in a shared package, prog_loader_pkg.
REQ-028 SHALL: byte shifting and the byte counter are a sub-module, word_assembler (byte in, word plus word_ready out), instantiated once for the length field and once for instruction words, or once shared with a width parameter.

Verification
REQ-029 SHALL: release reset, send 00 00 00 02, 11 22 33 44, AA BB CC DD (macro off) -> reset_pc pulses, then we pulses twice with inst_in=0x11223344 then 0xAABBCCDD, then reset_pc pulses and done=1.
REQ-030 SHALL: send N=0 -> no we pulse; reset_pc pulses twice in total; done=1.
REQ-031 SHALL: with macro on, send N=1, word 01 02 03 04, trailer 0x05 (XOR 00^00^00^01^01^02^03^04) -> done=1; resend with trailer 0x06 -> err=1, done=0, stall=1.
REQ-032 SHALL: send back-to-back bytes with rx_valid high on consecutive cycles, including during the we cycle -> all words are correct and none are dropped.
REQ-033 SHALL: pulse rstn low after 2 bytes of the second word, then send a full new stream -> the FSM restarts at S_PRE and memory words 0.. are rewritten from the new stream.
REQ-034 SHALL: with INST_MEM_WIDTH=2, send N=6 -> exactly 4 we pulses, the remaining words are consumed silently, and done=1.
